// File: rtl/i2s_transmitter.sv
// ---------------------------------------------------------------------------
// i2s_transmitter
//   I2S (Philips) master transmitter. Pops {left,right} stereo samples from a
//   sync FIFO with a one-cycle registered read, double-buffers them in a
//   shadow register and serializes each frame MSB-first on SD, with SCK and
//   WS generated from clk. All outputs are registered.
//
// Ports
//   clk               system clock
//   rst_n             synchronous, active-low reset
//   enable_i          1 = run, 0 = return to idle on the next clk
//   fifo_rd_en_o      one-clk pop request, only issued while FIFO non-empty
//   fifo_empty_i      FIFO empty flag
//   fifo_read_data_i  {left,right}, valid the clk after fifo_rd_en_o
//   i2s_sck_o         bit clock (period 2*CLK_DIV clk)
//   i2s_ws_o          word select, 0 = left, 1 = right (leads data by a bit)
//   i2s_sd_o          serial data, updated on SCK falling edges
//   underrun_o        one-clk pulse when a frame starts with no sample ready
//   busy_o            1 while prefetching or running
// ---------------------------------------------------------------------------
module i2s_transmitter #(
    parameter int DATA_WIDTH = 16,
    parameter int SLOT_WIDTH = 32,
    parameter int CLK_DIV    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable_i,
    output logic                    fifo_rd_en_o,
    input  logic                    fifo_empty_i,
    input  logic [2*DATA_WIDTH-1:0] fifo_read_data_i,
    output logic                    i2s_sck_o,
    output logic                    i2s_ws_o,
    output logic                    i2s_sd_o,
    output logic                    underrun_o,
    output logic                    busy_o
);

    localparam int CW   = $clog2(2 * SLOT_WIDTH);
    localparam int DIVW = $clog2(CLK_DIV);
    localparam int FW   = 2 * DATA_WIDTH;

    localparam logic [CW-1:0]   BIT_LAST    = CW'(2 * SLOT_WIDTH - 1);
    localparam logic [CW-1:0]   BIT_RSTART  = CW'(SLOT_WIDTH);
    localparam logic [CW-1:0]   BIT_ZERO    = CW'(0);
    localparam logic [DIVW-1:0] DIV_LAST    = DIVW'(CLK_DIV - 1);
    localparam logic [DIVW-1:0] DIV_ZERO    = DIVW'(0);
    localparam logic [DIVW-1:0] DIV_ONE     = DIVW'(1);
    localparam logic [CW-1:0]   BIT_ONE     = CW'(1);
    localparam logic [FW-1:0]   FRAME_ZERO  = {FW{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREFETCH = 2'd1,
        ST_RUN      = 2'd2
    } state_e;

    // Serial data bit for frame position b: left slot, then right slot,
    // each carrying DATA_WIDTH bits MSB-first followed by zero padding.
    function automatic logic sd_bit_f(input logic [FW-1:0] frame,
                                      input logic [CW-1:0] b);
        int            bi;
        logic [FW-1:0] sh;
        bi = int'(b);
        if (bi < DATA_WIDTH) begin
            sh = frame >> (FW - 1 - bi);
        end else if ((bi >= SLOT_WIDTH) && (bi < SLOT_WIDTH + DATA_WIDTH)) begin
            sh = frame >> (DATA_WIDTH - 1 - (bi - SLOT_WIDTH));
        end else begin
            sh = FRAME_ZERO;
        end
        return sh[0];
    endfunction

    // WS switches one bit ahead of the slot boundary it announces.
    function automatic logic ws_bit_f(input logic [CW-1:0] b);
        int bi;
        bi = int'(b);
        return (bi >= SLOT_WIDTH - 1) && (bi != 2 * SLOT_WIDTH - 1);
    endfunction

    state_e          state_q, state_d;
    logic [DIVW-1:0] div_q, div_d;
    logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [FW-1:0]   frame_q, frame_d;
    logic [FW-1:0]   shadow_q, shadow_d;
    logic            shadow_valid_q, shadow_valid_d;
    logic            rd_pend_q, rd_pend_d;
    logic            rd_en_q, rd_en_d;
    logic            sck_q, sck_d;
    logic            ws_q, ws_d;
    logic            sd_q, sd_d;
    logic            underrun_q, underrun_d;
    logic            busy_q, busy_d;
    logic [CW-1:0]   bit_next_s;

    // Next-state logic: sequencing, SCK divider, bit counter, frame/shadow handling.
    always_comb begin
        state_d        = state_q;
        div_d          = div_q;
        bit_cnt_d      = bit_cnt_q;
        frame_d        = frame_q;
        shadow_d       = shadow_q;
        shadow_valid_d = shadow_valid_q;
        // A pop issued last clk has its data on the bus this clk.
        rd_pend_d      = rd_en_q;
        rd_en_d        = 1'b0;
        sck_d          = sck_q;
        ws_d           = ws_q;
        sd_d           = sd_q;
        underrun_d     = 1'b0;
        bit_next_s     = (bit_cnt_q == BIT_LAST) ? BIT_ZERO : (bit_cnt_q + BIT_ONE);

        if (!enable_i) begin
            // Abandon everything, including data of a pop already in flight.
            state_d        = ST_IDLE;
            div_d          = DIV_ZERO;
            bit_cnt_d      = BIT_LAST;
            frame_d        = FRAME_ZERO;
            shadow_valid_d = 1'b0;
            rd_pend_d      = 1'b0;
            sck_d          = 1'b0;
            ws_d           = 1'b0;
            sd_d           = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_PREFETCH;
                end
                ST_PREFETCH: begin
                    if (rd_pend_q) begin
                        shadow_d       = fifo_read_data_i;
                        shadow_valid_d = 1'b1;
                        state_d        = ST_RUN;
                    end else if (!rd_en_q && !fifo_empty_i) begin
                        rd_en_d = 1'b1;
                    end else begin
                        rd_en_d = 1'b0;
                    end
                end
                ST_RUN: begin
                    if (rd_pend_q) begin
                        shadow_d       = fifo_read_data_i;
                        shadow_valid_d = 1'b1;
                    end else begin
                        shadow_d       = shadow_q;
                    end

                    if (div_q == DIV_LAST) begin
                        div_d = DIV_ZERO;
                        sck_d = ~sck_q;
                        if (sck_q) begin
                            // Falling edge: advance to the next bit position.
                            bit_cnt_d = bit_next_s;
                            if (bit_next_s == BIT_ZERO) begin
                                if (shadow_valid_q) begin
                                    frame_d        = shadow_q;
                                    shadow_valid_d = 1'b0;
                                end else begin
                                    frame_d    = FRAME_ZERO;
                                    underrun_d = 1'b1;
                                end
                            end else begin
                                frame_d = frame_q;
                            end
                            // Single refill attempt per frame, at the start of the right slot.
                            if ((bit_next_s == BIT_RSTART) && !fifo_empty_i) begin
                                rd_en_d = 1'b1;
                            end else begin
                                rd_en_d = 1'b0;
                            end
                            sd_d = sd_bit_f(frame_d, bit_next_s);
                            ws_d = ws_bit_f(bit_next_s);
                        end else begin
                            bit_cnt_d = bit_cnt_q;
                        end
                    end else begin
                        div_d = div_q + DIV_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            div_q          <= DIV_ZERO;
            bit_cnt_q      <= BIT_LAST;
            frame_q        <= FRAME_ZERO;
            shadow_q       <= FRAME_ZERO;
            shadow_valid_q <= 1'b0;
            rd_pend_q      <= 1'b0;
            rd_en_q        <= 1'b0;
            sck_q          <= 1'b0;
            ws_q           <= 1'b0;
            sd_q           <= 1'b0;
            underrun_q     <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            div_q          <= div_d;
            bit_cnt_q      <= bit_cnt_d;
            frame_q        <= frame_d;
            shadow_q       <= shadow_d;
            shadow_valid_q <= shadow_valid_d;
            rd_pend_q      <= rd_pend_d;
            rd_en_q        <= rd_en_d;
            sck_q          <= sck_d;
            ws_q           <= ws_d;
            sd_q           <= sd_d;
            underrun_q     <= underrun_d;
            busy_q         <= busy_d;
        end
    end

    assign fifo_rd_en_o = rd_en_q;
    assign i2s_sck_o    = sck_q;
    assign i2s_ws_o     = ws_q;
    assign i2s_sd_o     = sd_q;
    assign underrun_o   = underrun_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// ---------------------------------------------------------------------------
// tb_i2s_transmitter
//   Directed bench for i2s_transmitter: a frame table (FIFO pushes, expected
//   serial frame, underrun and pop counts per frame) plus hand-written
//   sequences for disable/re-enable, mid-frame reset and a CLK_DIV=3 /
//   DATA_WIDTH=24 instance.
// ---------------------------------------------------------------------------
module tb_i2s_transmitter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        fifo_rd_en;
    logic        fifo_empty = 1'b1;
    logic [31:0] fifo_data = 32'h0;
    logic        sck, ws, sd, underrun, busy;

    i2s_transmitter dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .enable_i         (enable),
        .fifo_rd_en_o     (fifo_rd_en),
        .fifo_empty_i     (fifo_empty),
        .fifo_read_data_i (fifo_data),
        .i2s_sck_o        (sck),
        .i2s_ws_o         (ws),
        .i2s_sd_o         (sd),
        .underrun_o       (underrun),
        .busy_o           (busy)
    );

    // Second instance: 24-bit samples, slower bit clock, FIFO never empty.
    logic        enable2 = 1'b0;
    logic        rd_en2;
    logic        empty2 = 1'b0;
    logic [47:0] data2 = 48'hABCDEF_123456;
    logic        sck2, ws2, sd2, underrun2, busy2;

    i2s_transmitter #(.DATA_WIDTH(24), .SLOT_WIDTH(32), .CLK_DIV(3)) dut2 (
        .clk              (clk),
        .rst_n            (rst_n),
        .enable_i         (enable2),
        .fifo_rd_en_o     (rd_en2),
        .fifo_empty_i     (empty2),
        .fifo_read_data_i (data2),
        .i2s_sck_o        (sck2),
        .i2s_ws_o         (ws2),
        .i2s_sd_o         (sd2),
        .underrun_o       (underrun2),
        .busy_o           (busy2)
    );

    int vectors = 0;
    int fails   = 0;

    // FIFO model with registered read and registered empty flag.
    logic [31:0] fifo_q[$];
    always @(posedge clk) begin
        if (fifo_rd_en && fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
        fifo_empty <= (fifo_q.size() == 0);
    end

    // Event monitor: SCK rises since busy, pops and underruns with their position.
    int   rises = 0;
    int   rd_cnt = 0, ur_cnt = 0, rd_empty_cnt = 0;
    int   rd_log[$];
    int   ur_log[$];
    logic sck_prev_m = 1'b0;
    always @(negedge clk) begin
        if (!busy) rises = 0;
        else if (sck && !sck_prev_m) rises = rises + 1;
        sck_prev_m = sck;
        if (fifo_rd_en) begin
            rd_cnt = rd_cnt + 1;
            rd_log.push_back(rises);
            if (fifo_empty) rd_empty_cnt = rd_empty_cnt + 1;
        end
        if (underrun) begin
            ur_cnt = ur_cnt + 1;
            ur_log.push_back(rises);
        end
    end

    // Capture of the second instance's bits on SCK rises.
    int   cyc2 = 0;
    logic sck2_prev = 1'b0;
    logic bits2[$];
    logic ws2q[$];
    int   t2[$];
    always @(negedge clk) begin
        cyc2 = cyc2 + 1;
        if (busy2 && sck2 && !sck2_prev && bits2.size() < 70) begin
            bits2.push_back(sd2);
            ws2q.push_back(ws2);
            t2.push_back(cyc2);
        end
        sck2_prev = sck2;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Wait for the next SCK rise of the main DUT; n = clks waited, hi = high samples.
    task automatic next_rise(output logic o_sd, output logic o_ws, output int n, output int hi);
        logic last;
        last = sck;
        n    = 0;
        hi   = 0;
        o_sd = 1'b0;
        o_ws = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n = n + 1;
            if (sck) hi = hi + 1;
            if (sck && !last) begin
                o_sd = sd;
                o_ws = ws;
                return;
            end
            last = sck;
        end
        vectors = vectors + 1;
        fails   = fails + 1;
        $display("FAIL sck_timeout: no SCK rise within 100 clk");
    endtask

    task automatic capture_frame(output logic [63:0] sdv, output logic [63:0] wsv, output logic tim_ok);
        logic s, w;
        int   n, hi;
        sdv    = 64'h0;
        wsv    = 64'h0;
        tim_ok = 1'b1;
        for (int b = 0; b < 64; b++) begin
            next_rise(s, w, n, hi);
            sdv = {sdv[62:0], s};
            wsv = {wsv[62:0], w};
            if (n != 4 || hi != 2) tim_ok = 1'b0;
        end
    endtask

    typedef struct {
        bit          do_push;
        logic [31:0] push_word;
        logic [31:0] exp_word;
        int          exp_ur;
        int          exp_rd;
    } vec_t;

    localparam logic [63:0] WS_EXP = 64'h0000_0001_FFFF_FFFE;

    initial begin
        vec_t        tbl[6];
        logic [63:0] sdv, wsv;
        logic        tok, s, w;
        logic [63:0] v2, w2;
        int          n, hi, rd0, ur0;
        string       nm;

        tbl[0] = '{1'b0, 32'h0,         32'hA5F0_0F0F, 0, 1};
        tbl[1] = '{1'b0, 32'h0,         32'h1234_5678, 0, 1};
        tbl[2] = '{1'b0, 32'h0,         32'hFFFF_8001, 0, 0};
        tbl[3] = '{1'b1, 32'h8000_0001, 32'h0000_0000, 1, 1};
        tbl[4] = '{1'b0, 32'h0,         32'h8000_0001, 0, 0};
        tbl[5] = '{1'b0, 32'h0,         32'h0000_0000, 1, 0};

        repeat (3) @(negedge clk);
        check("reset_outs", 64'({fifo_rd_en, sck, ws, sd, underrun, busy}), 64'h0);
        rst_n   = 1'b1;
        enable2 = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_outs", 64'({fifo_rd_en, sck, ws, sd, underrun, busy}), 64'h0);

        fifo_q.push_back(32'hA5F0_0F0F);
        fifo_q.push_back(32'h1234_5678);
        fifo_q.push_back(32'hFFFF_8001);
        repeat (2) @(negedge clk);
        enable = 1'b1;
        next_rise(s, w, n, hi);
        check("prefetch_pop", 64'(rd_cnt), 64'd1);

        for (int f = 0; f < 6; f++) begin
            rd0 = rd_cnt;
            ur0 = ur_cnt;
            if (tbl[f].do_push) fifo_q.push_back(tbl[f].push_word);
            capture_frame(sdv, wsv, tok);
            nm = $sformatf("frame%0d_sd", f);
            check(nm, sdv, {tbl[f].exp_word[31:16], 16'h0, tbl[f].exp_word[15:0], 16'h0});
            nm = $sformatf("frame%0d_ws", f);
            check(nm, wsv, WS_EXP);
            nm = $sformatf("frame%0d_underrun", f);
            check(nm, 64'(ur_cnt - ur0), 64'(tbl[f].exp_ur));
            nm = $sformatf("frame%0d_pops", f);
            check(nm, 64'(rd_cnt - rd0), 64'(tbl[f].exp_rd));
            nm = $sformatf("frame%0d_sck_timing", f);
            check(nm, 64'(tok), 64'd1);
        end

        // Disable in the right slot after a sample was popped; it must be dropped.
        fifo_q.push_back(32'hDEAD_BEEF);
        for (int i = 0; i < 41; i++) next_rise(s, w, n, hi);
        enable = 1'b0;
        @(negedge clk);
        check("disable_outs", 64'({fifo_rd_en, sck, ws, sd, busy}), 64'h0);
        fifo_q.push_back(32'h5555_AAAA);
        repeat (3) @(negedge clk);
        check("disable_idle", 64'({sck, ws, sd, busy}), 64'h0);
        enable = 1'b1;
        rd0 = rd_cnt;
        next_rise(s, w, n, hi);
        check("reenable_pop", 64'(rd_cnt - rd0), 64'd1);
        capture_frame(sdv, wsv, tok);
        check("reenable_sd", sdv, {16'h5555, 16'h0, 16'hAAAA, 16'h0});
        check("reenable_ws", wsv, WS_EXP);

        // One-clk reset in the middle of a frame with enable held high.
        for (int i = 0; i < 10; i++) next_rise(s, w, n, hi);
        rst_n = 1'b0;
        @(negedge clk);
        check("midframe_reset", 64'({fifo_rd_en, sck, ws, sd, underrun, busy}), 64'h0);
        rst_n = 1'b1;

        // 24-bit / CLK_DIV=3 instance: bits2[0] is the rise before the first frame.
        for (int i = 0; i < 3000 && bits2.size() < 66; i++) @(negedge clk);
        if (bits2.size() < 66) begin
            vectors = vectors + 1;
            fails   = fails + 1;
            $display("FAIL dw24_capture: got %0d rises, expected at least 66", bits2.size());
        end else begin
            v2 = 64'h0;
            w2 = 64'h0;
            for (int b = 1; b <= 64; b++) begin
                v2 = {v2[62:0], bits2[b]};
                w2 = {w2[62:0], ws2q[b]};
            end
            check("dw24_sd", v2, {24'hABCDEF, 8'h0, 24'h123456, 8'h0});
            check("dw24_ws", w2, WS_EXP);
            check("dw24_sck_period", 64'(t2[2] - t2[1]), 64'd6);
            check("dw24_frame_period", 64'(t2[65] - t2[1]), 64'd384);
        end

        // Every pop is in PREFETCH or at the start of a right slot; underruns at frame starts.
        foreach (rd_log[i]) begin
            check("pop_position", 64'((rd_log[i] == 0) || (rd_log[i] >= 33 && (rd_log[i] - 33) % 64 == 0)), 64'd1);
        end
        foreach (ur_log[i]) begin
            check("underrun_position", 64'(rd_log.size() > 0 && ur_log[i] >= 1 && (ur_log[i] - 1) % 64 == 0), 64'd1);
        end
        check("pop_while_empty", 64'(rd_empty_cnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
